// File: rtl/adder_tree_pipe_pkg.sv
// Shared helpers for the pipelined adder tree: tree depth and per-level widths.
package adder_tree_pkg;

  // Number of tree levels (= pipeline latency); a single operand still gets one level.
  function automatic int tree_depth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width of a partial sum after s levels of pairwise addition of w-bit operands.
  function automatic int stage_width(input int w, input int s);
    return w + s;
  endfunction

  // Operand count after padding up to a full binary tree.
  function automatic int padded_count(input int n);
    return 1 << tree_depth(n);
  endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Operand/result handshake bundle for adder_tree_pipe.
// With ADDER_TREE_PIPE_ACC_EN defined, an in_last tag travels with each vector
// and RES_W defaults to the widened accumulator width.
interface adder_tree_pipe_if
  import adder_tree_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
`ifdef ADDER_TREE_PIPE_ACC_EN
  parameter int RES_W = W + tree_depth(N) + 8
`else
  parameter int RES_W = W + tree_depth(N)
`endif
) ();

  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_data;
`ifdef ADDER_TREE_PIPE_ACC_EN
  logic             in_last;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_data;

  // Producer / consumer side (testbench, surrounding logic).
  modport master (
`ifdef ADDER_TREE_PIPE_ACC_EN
    output in_last,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The adder tree itself.
  modport slave (
`ifdef ADDER_TREE_PIPE_ACC_EN
    input  in_last,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/adder_tree_pipe_stage.sv
// One registered level of the adder tree: PAIRS pairwise sums of IN_W-bit
// children, each widened by one bit (sign- or zero-extension per SIGNED).
module adder_tree_stage
  import adder_tree_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int PAIRS  = 1,
  parameter bit SIGNED = 1'b0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic                                     in_valid,
  input  logic [2*PAIRS*IN_W-1:0]                  in_data,
  output logic                                     out_valid,
  output logic [PAIRS*stage_width(IN_W, 1)-1:0]    out_data
);

  localparam int OUT_W = stage_width(IN_W, 1);

  logic [PAIRS*OUT_W-1:0] sum_next;
  logic [PAIRS*OUT_W-1:0] data_reg;
  logic                   valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < PAIRS; gi++) begin : gen_pair
      logic [IN_W-1:0] a;
      logic [IN_W-1:0] b;
      logic            ext_a;
      logic            ext_b;
      assign a     = in_data[(2*gi)*IN_W   +: IN_W];
      assign b     = in_data[(2*gi+1)*IN_W +: IN_W];
      assign ext_a = SIGNED ? a[IN_W-1] : 1'b0;
      assign ext_b = SIGNED ? b[IN_W-1] : 1'b0;
      assign sum_next[gi*OUT_W +: OUT_W] = {ext_a, a} + {ext_b, b};
    end
  endgenerate

  // Level register: moves only on enable; data captured only for valid entries
  // so the last valid sum stays visible across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (en) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= sum_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined, fully registered adder tree with valid/ready flow control.
// Sums N operands of W bits in L = tree_depth(N) registered levels; the whole
// pipeline stalls together while a result waits for out_ready.
// Optional macro ADDER_TREE_PIPE_ACC_EN: adds an in_last-delimited group
// accumulator after the tree (result width ACC_W, latency L+1).
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter bit SIGNED = 1'b0
`ifdef ADDER_TREE_PIPE_ACC_EN
  , parameter int ACC_W = W + tree_depth(N) + 8
`endif
) (
  input logic              clk,
  input logic              rst,
  adder_tree_pipe_if.slave bus
);

  localparam int L     = tree_depth(N);
  localparam int OUT_W = stage_width(W, L);
  localparam int P     = padded_count(N);

  logic             adv;
  logic             accept;
  logic             out_valid_int;
  logic [P*W-1:0]   lvl0_data;
  logic [OUT_W-1:0] tree_sum;
  logic             tree_valid;

  // A single stall condition shared by every level keeps vectors in lockstep.
  assign adv         = !out_valid_int || bus.out_ready;
  assign bus.in_ready = adv && !rst;
  assign accept      = bus.in_valid && bus.in_ready;

  genvar gi;
  generate
    // Leaves: real operands followed by zero padding up to a power of two.
    for (gi = 0; gi < P; gi++) begin : gen_leaf
      if (gi < N) begin : g_op
        assign lvl0_data[gi*W +: W] = bus.in_data[gi*W +: W];
      end else begin : g_pad
        assign lvl0_data[gi*W +: W] = '0;
      end
    end

    // One registered level per tree depth; level gi halves the operand count.
    for (gi = 0; gi < L; gi++) begin : gen_lvl
      localparam int IN_W  = stage_width(W, gi);
      localparam int PAIRS = P >> (gi + 1);

      logic [2*PAIRS*IN_W-1:0]   src_data;
      logic                      src_valid;
      logic [PAIRS*(IN_W+1)-1:0] sum;
      logic                      sum_valid;

      if (gi == 0) begin : g_first
        assign src_data  = lvl0_data;
        assign src_valid = accept;
      end else begin : g_next
        assign src_data  = gen_lvl[gi-1].sum;
        assign src_valid = gen_lvl[gi-1].sum_valid;
      end

      adder_tree_stage #(
        .IN_W   (IN_W),
        .PAIRS  (PAIRS),
        .SIGNED (SIGNED)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (adv),
        .in_valid  (src_valid),
        .in_data   (src_data),
        .out_valid (sum_valid),
        .out_data  (sum)
      );
    end
  endgenerate

  assign tree_sum   = gen_lvl[L-1].sum;
  assign tree_valid = gen_lvl[L-1].sum_valid;

`ifdef ADDER_TREE_PIPE_ACC_EN
  logic [L-1:0]     last_pipe_reg;
  logic             tree_last;
  logic [ACC_W-1:0] tree_ext;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] out_data_reg;
  logic             out_valid_reg;

  // The group-end tag shifts alongside the tree levels, one slot per level.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pipe_reg <= '0;
    end else if (adv) begin
      last_pipe_reg[0] <= bus.in_last;
      for (int i = 1; i < L; i++) begin
        last_pipe_reg[i] <= last_pipe_reg[i-1];
      end
    end
  end

  assign tree_last = last_pipe_reg[L-1];

  if (SIGNED) begin : g_ext_s
    assign tree_ext = {{(ACC_W-OUT_W){tree_sum[OUT_W-1]}}, tree_sum};
  end else begin : g_ext_u
    assign tree_ext = {{(ACC_W-OUT_W){1'b0}}, tree_sum};
  end

  assign acc_sum = acc_reg + tree_ext;

  // Running group total; publishes and clears on the tagged last vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (adv) begin
      if (tree_valid && tree_last) begin
        out_data_reg  <= acc_sum;
        out_valid_reg <= 1'b1;
        acc_reg       <= '0;
      end else begin
        out_valid_reg <= 1'b0;
        if (tree_valid) begin
          acc_reg <= acc_sum;
        end
      end
    end
  end

  assign out_valid_int = out_valid_reg;
  assign bus.out_data  = out_data_reg;
`else
  assign out_valid_int = tree_valid;
  assign bus.out_data  = tree_sum;
`endif

  assign bus.out_valid = out_valid_int;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: an unsigned N=4 instance and a
// signed N=5 instance share clock and reset. A scoreboard queue per instance
// is filled on acceptance and drained on each output transfer.
module tb_adder_tree_pipe;
  import adder_tree_pkg::*;

`ifdef ADDER_TREE_PIPE_ACC_EN
  localparam int RES4 = 18;
  localparam int RES5 = 19;
`else
  localparam int RES4 = 10;
  localparam int RES5 = 11;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int out_cnt4 = 0;
  int out_cnt5 = 0;
  bit acc4;
  logic [RES4-1:0] q4[$];
  logic [RES5-1:0] q5[$];
`ifdef ADDER_TREE_PIPE_ACC_EN
  logic [RES4-1:0] acc_model4;
`endif

  adder_tree_pipe_if #(.N(4), .W(8), .RES_W(RES4)) if4 ();
  adder_tree_pipe_if #(.N(5), .W(8), .RES_W(RES5)) if5 ();

  adder_tree_pipe #(.N(4), .W(8), .SIGNED(1'b0)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  adder_tree_pipe #(.N(5), .W(8), .SIGNED(1'b1)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

  function automatic logic [RES4-1:0] model4(input logic [31:0] d);
    logic [RES4-1:0] s = '0;
    for (int i = 0; i < 4; i++) s += RES4'(d[i*8 +: 8]);
    return s;
  endfunction

  function automatic logic [RES5-1:0] model5(input logic [39:0] d);
    int s = 0;
    for (int i = 0; i < 5; i++) s += int'($signed(d[i*8 +: 8]));
    return RES5'(s);
  endfunction

  // One clock: scoreboard at the falling edge, then return 1 time unit after the rising edge.
  task automatic sb_cycle();
    logic [RES4-1:0] exp4;
    logic [RES5-1:0] exp5;
    @(negedge clk);
    acc4 = 1'b0;
    if (rst) begin
      q4.delete();
      q5.delete();
`ifdef ADDER_TREE_PIPE_ACC_EN
      acc_model4 = '0;
`endif
    end else begin
      if (if4.out_valid && if4.out_ready) begin
        checks++;
        out_cnt4++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL sb4_unexpected: out_data=%0d appeared, no result expected", if4.out_data);
        end else begin
          exp4 = q4.pop_front();
          if (if4.out_data !== exp4) begin
            errors++;
            $display("FAIL sb4_data: out_data=%0d expected %0d", if4.out_data, exp4);
          end
        end
      end
      if (if5.out_valid && if5.out_ready) begin
        checks++;
        out_cnt5++;
        if (q5.size() == 0) begin
          errors++;
          $display("FAIL sb5_unexpected: out_data=%0d appeared, no result expected", $signed(if5.out_data));
        end else begin
          exp5 = q5.pop_front();
          if (if5.out_data !== exp5) begin
            errors++;
            $display("FAIL sb5_data: out_data=%0d expected %0d", $signed(if5.out_data), $signed(exp5));
          end
        end
      end
      if (if4.in_valid && if4.in_ready) begin
        acc4 = 1'b1;
`ifdef ADDER_TREE_PIPE_ACC_EN
        acc_model4 += model4(if4.in_data);
        if (if4.in_last) begin
          q4.push_back(acc_model4);
          acc_model4 = '0;
        end
`else
        q4.push_back(model4(if4.in_data));
`endif
      end
`ifndef ADDER_TREE_PIPE_ACC_EN
      if (if5.in_valid && if5.in_ready) q5.push_back(model5(if5.in_data));
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) sb_cycle();
    checks += 6;
    if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready4: got %b expected 0", if4.in_ready); end
    if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid4: got %b expected 0", if4.out_valid); end
    if (if4.out_data !== '0) begin errors++; $display("FAIL reset_out_data4: got %0d expected 0", if4.out_data); end
    if (if5.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready5: got %b expected 0", if5.in_ready); end
    if (if5.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid5: got %b expected 0", if5.out_valid); end
    if (if5.out_data !== '0) begin errors++; $display("FAIL reset_out_data5: got %0d expected 0", if5.out_data); end
    rst = 1'b0;
    sb_cycle();
    checks++;
    if (if4.in_ready !== 1'b1 || if5.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %b/%b expected 1/1", if4.in_ready, if5.in_ready);
    end
  endtask

`ifdef ADDER_TREE_PIPE_ACC_EN
  task automatic test_accumulate();
    int n_out;
    int first_c;
    logic [RES4-1:0] got;
    for (int g = 0; g < 2; g++) begin
      n_out = 0;
      first_c = -1;
      got = '0;
      for (int c = 0; c < 9; c++) begin
        // Group 0: three {1,1,1,1} vectors, last tagged. Group 1: one {2,2,2,2} tagged last.
        if (g == 0) begin
          if4.in_valid = (c < 3);
          if4.in_data  = {4{8'd1}};
          if4.in_last  = (c == 2);
        end else begin
          if4.in_valid = (c == 0);
          if4.in_data  = {4{8'd2}};
          if4.in_last  = (c == 0);
        end
        sb_cycle();
        if (if4.out_valid) begin
          n_out++;
          if (first_c < 0) begin
            first_c = c;
            got = if4.out_data;
          end
        end
      end
      if4.in_valid = 1'b0;
      if4.in_last  = 1'b0;
      checks += 3;
      if (n_out !== 1) begin errors++; $display("FAIL acc_out_count g%0d: got %0d expected 1", g, n_out); end
      if (got !== ((g == 0) ? RES4'(12) : RES4'(8))) begin
        errors++;
        $display("FAIL acc_total g%0d: got %0d expected %0d", g, got, (g == 0) ? 12 : 8);
      end
      if (first_c !== ((g == 0) ? 4 : 2)) begin
        errors++;
        $display("FAIL acc_latency g%0d: out_valid at cycle %0d expected %0d", g, first_c, (g == 0) ? 4 : 2);
      end
    end
  endtask
`else
  task automatic test_unsigned_max();
    if4.in_valid = 1'b1;
    if4.in_data  = {4{8'hFF}};
    sb_cycle();
    if4.in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (if4.out_valid !== (c == 2)) begin
        errors++;
        $display("FAIL max4_valid c%0d: got %b expected %b", c, if4.out_valid, c == 2);
      end
      if (c == 2) begin
        checks++;
        if (if4.out_data !== 10'd1020) begin errors++; $display("FAIL max4_data: got %0d expected 1020", if4.out_data); end
      end
      sb_cycle();
    end
  endtask

  task automatic test_signed_padding();
    logic [39:0] vecs [2];
    logic [10:0] exps [2];
    vecs[0] = {5{8'h80}};
    exps[0] = 11'h580;
    vecs[1] = {8'd100, 8'h80, 8'd5, 8'hFF, 8'd127};
    exps[1] = 11'd103;
    for (int v = 0; v < 2; v++) begin
      if5.in_valid = 1'b1;
      if5.in_data  = vecs[v];
      sb_cycle();
      if5.in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        checks++;
        if (if5.out_valid !== (c == 3)) begin
          errors++;
          $display("FAIL sgn5_valid v%0d c%0d: got %b expected %b", v, c, if5.out_valid, c == 3);
        end
        if (c == 3) begin
          checks++;
          if (if5.out_data !== exps[v]) begin
            errors++;
            $display("FAIL sgn5_data v%0d: got 0x%h expected 0x%h", v, if5.out_data, exps[v]);
          end
        end
        sb_cycle();
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int n_out = 0;
    int first_c = -1;
    int last_c = -1;
    for (int c = 0; c < 14; c++) begin
      if4.in_valid = (c < 10);
      if4.in_data  = {4{8'(c + 1)}};
      sb_cycle();
      if (acc4) n_acc++;
      if (if4.out_valid) begin
        n_out++;
        if (first_c < 0) first_c = c;
        last_c = c;
        checks++;
        if (if4.out_data !== 10'(4 * n_out)) begin
          errors++;
          $display("FAIL b2b_data #%0d: got %0d expected %0d", n_out, if4.out_data, 4 * n_out);
        end
      end
    end
    if4.in_valid = 1'b0;
    checks += 3;
    if (n_acc !== 10) begin errors++; $display("FAIL b2b_accepted: got %0d expected 10", n_acc); end
    if (n_out !== 10) begin errors++; $display("FAIL b2b_out_count: got %0d expected 10", n_out); end
    if (last_c - first_c !== 9) begin errors++; $display("FAIL b2b_contiguous: span %0d expected 9", last_c - first_c); end
  endtask

  task automatic test_stall();
    int sent = 0;
    int base_out = out_cnt4;
    logic [9:0] held;
    for (int c = 0; c < 30; c++) begin
      if4.out_ready = !(c >= 6 && c < 10);
      if4.in_valid  = (sent < 12);
      if4.in_data   = {8'(sent * 3 + 1), 8'(sent * 7), 8'(200 - sent), 8'(sent)};
      #1;
      if (c >= 6 && c < 10) begin
        checks += 2;
        if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b expected 0", c, if4.in_ready); end
        if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid c%0d: got %b expected 1", c, if4.out_valid); end
        if (c == 6) held = if4.out_data;
        else begin
          checks++;
          if (if4.out_data !== held) begin errors++; $display("FAIL stall_hold c%0d: got %0d expected %0d", c, if4.out_data, held); end
        end
      end
      sb_cycle();
      if (acc4) sent++;
    end
    if4.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    checks += 2;
    if (sent !== 12) begin errors++; $display("FAIL stall_sent: got %0d expected 12", sent); end
    if (out_cnt4 - base_out !== 12) begin errors++; $display("FAIL stall_out_count: got %0d expected 12", out_cnt4 - base_out); end
  endtask

  task automatic test_reset_mid();
    if4.in_valid = 1'b1;
    if4.in_data  = {4{8'd9}};
    sb_cycle();
    if4.in_data  = {4{8'd20}};
    sb_cycle();
    if4.in_valid = 1'b0;
    rst = 1'b1;
    sb_cycle();
    checks += 3;
    if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b expected 0", if4.out_valid); end
    if (if4.out_data !== '0) begin errors++; $display("FAIL rmid_out_data: got %0d expected 0", if4.out_data); end
    if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready: got %b expected 0", if4.in_ready); end
    rst = 1'b0;
    if4.in_valid = 1'b1;
    if4.in_data  = {4{8'd50}};
    sb_cycle();
    if4.in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (if4.out_valid !== (c == 2)) begin
        errors++;
        $display("FAIL rmid_post_valid c%0d: got %b expected %b", c, if4.out_valid, c == 2);
      end
      if (c == 2) begin
        checks++;
        if (if4.out_data !== 10'd200) begin errors++; $display("FAIL rmid_post_data: got %0d expected 200", if4.out_data); end
      end
      sb_cycle();
    end
  endtask
`endif

  task automatic drain();
    if4.in_valid  = 1'b0;
    if5.in_valid  = 1'b0;
    if4.out_ready = 1'b1;
    if5.out_ready = 1'b1;
    for (int c = 0; c < 20 && (q4.size() != 0 || q5.size() != 0); c++) sb_cycle();
    checks++;
    if (q4.size() != 0 || q5.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d results still outstanding, expected 0/0", q4.size(), q5.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    if4.in_valid = 1'b0;
    if4.in_data  = '0;
    if4.out_ready = 1'b1;
    if5.in_valid = 1'b0;
    if5.in_data  = '0;
    if5.out_ready = 1'b1;
`ifdef ADDER_TREE_PIPE_ACC_EN
    if4.in_last = 1'b0;
    if5.in_last = 1'b0;
    acc_model4 = '0;
`endif
    @(posedge clk);
    #1;
    test_reset();
`ifdef ADDER_TREE_PIPE_ACC_EN
    test_accumulate();
`else
    test_unsigned_max();
    test_signed_padding();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`endif
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
- Parametrised, pipelined, fully registered adder tree: sums N operands of W bits into one result, one registered stage per tree level.
- Generalises the fixed 8-bit unsigned tree: arbitrary N (non-power-of-two padded), arbitrary W, signed or unsigned operands.
- Adds valid/ready flow control with pipeline stall.
- Sits between operand producers (e.g. MAC/dot-product lanes) and downstream writeback/accumulate logic.

Parameters:
- N, 4, number of input operands (N >= 1).
- W, 8, operand width in bits.
- SIGNED, 0, 1 = operands are two's complement and are sign-extended; 0 = unsigned, zero-extended.
- L, max(1, $clog2(N)), tree depth = pipeline latency in cycles (derived; do not override).
- OUT_W, W+L, result width (derived).

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand vector valid.
- in_ready  output  1  block can accept the vector this cycle.
- in_data  input  N*W  operands packed flat; operand i at [i*W +: W].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  OUT_W  sum of the N operands.

Behaviour:
- Reset: synchronous, active-high. All stage valid bits = 0, out_valid = 0, out_data = 0; in_ready = 0 while rst is high.
- Advance: adv = !out_valid || out_ready. Every stage register loads only when adv = 1; otherwise the whole pipeline holds (global stall). in_ready = adv when rst = 0.
- Input acceptance: a vector is accepted when in_valid && in_ready.
- Bubbles: a bubble (in_valid = 0 with adv = 1) enters stage 1 with valid = 0. Data registers of invalid stages are don't-care, but out_data must hold its last value while out_valid = 0.
- Padding: operands N..2^L-1 are treated as 0.
- Stage widths: stage s (1..L) holds 2^(L-s) partial sums of width W+s. Each sum is the sign- or zero-extension (per SIGNED) of its two stage-(s-1) children.
- Overflow: none possible; OUT_W is exact for the full operand range, including SIGNED = 1 with all operands at the most negative value.
- N = 1: L = 1; the result is the operand extended by one bit, after one cycle.
- Latency: out_valid rises exactly L cycles after acceptance if out_ready stays high. Throughput is 1 vector per cycle.
- Stall: out_valid && !out_ready holds out_data, out_valid and all internal stages stable; no vector is lost or duplicated.
- Reset mid-operation: all in-flight vectors are discarded and out_valid = 0 in the cycle after rst is sampled high.
- Simultaneous in_valid with a downstream stall: not accepted (in_ready = 0); the upstream keeps in_data stable.

Optional Feature:
- Macro: ADDER_TREE_PIPE_ACC_EN.
- Defined:
  - Adds input port in_last (1 bit, travels with the vector) and parameter ACC_W (default OUT_W+8).
  - out_data widens to ACC_W.
  - After the tree, an accumulator register sums successive tree results, sign- or zero-extended per SIGNED.
  - out_valid asserts only for the vector tagged in_last, with out_data = accumulated total including that vector; the accumulator then clears to 0 for the next group.
  - Non-last results update the accumulator only when adv = 1.
  - Latency becomes L+1.
  - rst clears the accumulator.
  - Wrap-around modulo 2^ACC_W is accepted behaviour.
- Undefined: no in_last port, no accumulator; behaviour exactly as above.

Decomposition:
- Package adder_tree_pkg: function tree_depth(n) returning max(1, clog2(n)); function stage_width(w, s).
- One sub-module: adder_tree_stage, parameterised by input width and pair count; one registered level with valid and enable.
- Top instantiates L stages in a generate loop, plus the optional accumulator.

Test Plan:
- N=4, W=8, SIGNED=0, out_ready=1; apply {255,255,255,255} -> out_data=1020 exactly 2 cycles after acceptance, out_valid high 1 cycle.
- N=5, W=8, SIGNED=1; apply {-128,-128,-128,-128,-128} -> L=3, out_data=-640 (11-bit 0x580) after 3 cycles; padding lanes contribute 0.
- Back-to-back stream of 10 vectors {k,k,k,k} for k=1..10 (N=4, W=8, SIGNED=0, out_ready=1) -> 10 consecutive out_valid cycles with sums 4,8,...,40; no bubbles.
- Stall: hold out_ready=0 for 4 cycles while streaming -> in_ready=0 once out_valid=1; out_data stable; after release, all sums emerge in order, none lost or duplicated.
- Reset mid-stream: assert rst with 2 vectors in flight -> next cycle out_valid=0, out_data=0, in_ready=0; first post-reset vector gives the correct sum with latency L.
- ADDER_TREE_PIPE_ACC_EN: N=4, W=8, SIGNED=0; 3 vectors {1,1,1,1}, last tagged in_last -> single out_valid with out_data=12; next group starts from 0.
